// File: rtl/mx_dot_acc.sv
// mx_dot_acc: streaming MX block dot-product accumulator.
// Sums exactly K signed element products per block and captures the two
// shared E8M0 block scales on the first element. It emits one registered
// result per block (sum plus combined scale) through a valid/ready handshake.
// Optional build macro: MX_DOT_ACC_SAT_EN. When it is defined and
// out_width < acc_width, the result saturates. Otherwise it wraps.
module mx_dot_acc #(
    parameter int prd_width   = 16,
    parameter int K           = 32,
    parameter int scale_width = 8,
    parameter int acc_width   = prd_width + $clog2(K),
    parameter int out_width   = acc_width
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [prd_width-1:0] i_prd,
    input  logic [scale_width-1:0]      i_scale0,
    input  logic [scale_width-1:0]      i_scale1,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [out_width-1:0] o_acc,
    output logic [scale_width:0]        o_scale,
    output logic                        o_first
);

    localparam int cnt_width = $clog2(K);
    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(K - 1);

    logic [cnt_width-1:0]        count_reg, count_next;
    logic signed [acc_width-1:0] acc_reg, acc_next;
    logic signed [acc_width-1:0] prd_ext, sum;
    logic [scale_width:0]        scale_reg, scale_next, scale_sum;
    logic [scale_width:0]        o_scale_reg, o_scale_next;
    logic signed [out_width-1:0] o_acc_reg, o_acc_next, conv;
    logic                        valid_reg, valid_next;
    logic                        in_xfer, out_xfer, is_first, is_last;

    assign prd_ext   = acc_width'(i_prd);
    assign sum       = acc_reg + prd_ext;
    assign scale_sum = (scale_width+1)'(i_scale0) + (scale_width+1)'(i_scale1);

    assign is_first = (count_reg == '0);
    assign is_last  = (count_reg == last_cnt);

    // Ready does not depend on i_valid. A held result blocks input only while downstream stalls.
    assign o_ready  = ~valid_reg | i_ready;
    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = valid_reg & i_ready;

    // Narrow the full-precision block sum to the output width.
    generate
        if (out_width >= acc_width) begin : g_ext
            assign conv = out_width'(sum);
        end else begin : g_narrow
`ifdef MX_DOT_ACC_SAT_EN
            localparam logic signed [acc_width-1:0] sat_max =
                {{(acc_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
            localparam logic signed [acc_width-1:0] sat_min =
                {{(acc_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};
            assign conv = (sum > sat_max) ? out_width'(sat_max) :
                          (sum < sat_min) ? out_width'(sat_min) :
                                            sum[out_width-1:0];
`else
            assign conv = sum[out_width-1:0];
`endif
        end
    endgenerate

    // Next-state logic for the counter, accumulator, scale capture and result register.
    always_comb begin
        count_next   = count_reg;
        acc_next     = acc_reg;
        scale_next   = scale_reg;
        o_acc_next   = o_acc_reg;
        o_scale_next = o_scale_reg;
        valid_next   = valid_reg;

        // A result that is consumed now frees the output slot. A last element
        // accepted in the same cycle sets valid again below, so no result is lost.
        if (out_xfer) begin
            valid_next = 1'b0;
        end

        if (in_xfer) begin
            if (is_first) begin
                // The first element overwrites any stale sum from the previous block.
                acc_next   = prd_ext;
                scale_next = scale_sum;
            end else begin
                acc_next = sum;
            end

            if (is_last) begin
                count_next   = '0;
                o_acc_next   = conv;
                o_scale_next = scale_reg;
                valid_next   = 1'b1;
            end else begin
                count_next = count_reg + cnt_width'(1);
            end
        end
    end

    // State registers. The asynchronous reset discards any partial block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg   <= '0;
            acc_reg     <= '0;
            scale_reg   <= '0;
            o_acc_reg   <= '0;
            o_scale_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            scale_reg   <= scale_next;
            o_acc_reg   <= o_acc_next;
            o_scale_reg <= o_scale_next;
            valid_reg   <= valid_next;
        end
    end

    assign o_valid = valid_reg;
    assign o_acc   = o_acc_reg;
    assign o_scale = o_scale_reg;
    assign o_first = is_first;

endmodule

// File: tb/tb_mx_dot_acc.sv
// Directed testbench for mx_dot_acc with K=4 and 16-bit products.
// dut_a uses the full 18-bit output. dut_s uses a 16-bit output whose
// expected values depend on MX_DOT_ACC_SAT_EN.
module tb_mx_dot_acc;

    logic               i_clk    = 1'b0;
    logic               i_rst_n  = 1'b1;
    logic               i_valid  = 1'b0;
    logic               i_ready  = 1'b1;
    logic signed [15:0] i_prd    = '0;
    logic [7:0]         i_scale0 = '0;
    logic [7:0]         i_scale1 = '0;

    logic               o_ready_a, o_valid_a, o_first_a;
    logic signed [17:0] o_acc_a;
    logic [8:0]         o_scale_a;
    logic               o_ready_s, o_valid_s, o_first_s;
    logic signed [15:0] o_acc_s;
    logic [8:0]         o_scale_s;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MX_DOT_ACC_SAT_EN
    localparam longint SAT_POS = 32767;
    localparam longint SAT_NEG = -32768;
`else
    localparam longint SAT_POS = 0;
    localparam longint SAT_NEG = 0;
`endif

    mx_dot_acc #(.prd_width(16), .K(4), .scale_width(8)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_a),
        .i_prd(i_prd), .i_scale0(i_scale0), .i_scale1(i_scale1),
        .o_valid(o_valid_a), .i_ready(i_ready), .o_acc(o_acc_a),
        .o_scale(o_scale_a), .o_first(o_first_a)
    );

    mx_dot_acc #(.prd_width(16), .K(4), .scale_width(8), .out_width(16)) dut_s (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_s),
        .i_prd(i_prd), .i_scale0(i_scale0), .i_scale1(i_scale1),
        .o_valid(o_valid_s), .i_ready(i_ready), .o_acc(o_acc_s),
        .o_scale(o_scale_s), .o_first(o_first_s)
    );

    always #5 i_clk = ~i_clk;

    // Stop the run with a failure if it exceeds its time budget.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Present one product for one clock edge, then return #1 after that edge.
    task automatic push(input logic signed [15:0] p, input logic [7:0] s0, input logic [7:0] s1);
        i_valid  = 1'b1;
        i_prd    = p;
        i_scale0 = s0;
        i_scale1 = s1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    logic signed [15:0] st_prd [12] = '{1, 2, 3, 4, -1, -2, -3, -4, 5, -5, 3, -3};
    logic [7:0]         st_s0  [3]  = '{1, 200, 255};
    logic [7:0]         st_s1  [3]  = '{2, 100, 255};
    longint             st_sum [3]  = '{10, -10, 0};
    longint             st_scl [3]  = '{3, 300, 510};

    initial begin
        // Reset state
        #1 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid_a, 0);
        chk("rst_acc", o_acc_a, 0);
        chk("rst_scale", o_scale_a, 0);
        chk("rst_first", o_first_a, 1);
        chk("rst_ready", o_ready_a, 1);
        i_rst_n = 1'b1;

        // Basic block
        i_ready = 1'b1;
        push(1, 127, 130);
        chk("b1_first_after_e0", o_first_a, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        chk("b1_valid_pre", o_valid_a, 0);
        push(4, 0, 0);
        chk("b1_valid", o_valid_a, 1);
        chk("b1_acc", o_acc_a, 10);
        chk("b1_scale", o_scale_a, 257);
        chk("b1_first", o_first_a, 1);
        @(posedge i_clk); #1;
        chk("b1_valid_clr", o_valid_a, 0);

        // Extreme products: full-width sum and narrow saturate/wrap
        repeat (4) push(-32768, 0, 0);
        chk("neg_acc", o_acc_a, -131072);
        chk("neg_acc_s", o_acc_s, SAT_NEG);
        repeat (4) push(16384, 0, 0);
        chk("pos_acc", o_acc_a, 65536);
        chk("pos_acc_s", o_acc_s, SAT_POS);
        @(posedge i_clk); #1;
        chk("pos_valid_clr", o_valid_a, 0);

        // Backpressure holds the result and freezes input
        i_ready = 1'b0;
        push(1, 3, 4);
        push(2, 0, 0);
        push(3, 0, 0);
        push(4, 0, 0);
        chk("bp_valid", o_valid_a, 1);
        chk("bp_acc", o_acc_a, 10);
        i_valid  = 1'b1;
        i_prd    = 7;
        i_scale0 = 10;
        i_scale1 = 20;
        #1;
        chk("bp_ready_low", o_ready_a, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            chk("bp_hold_acc", o_acc_a, 10);
            chk("bp_hold_scale", o_scale_a, 7);
            chk("bp_hold_valid", o_valid_a, 1);
            chk("bp_hold_first", o_first_a, 1);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_ready_high", o_ready_a, 1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("bp_consumed", o_valid_a, 0);
        chk("bp_count1", o_first_a, 0);
        push(1, 0, 0);
        push(1, 0, 0);
        push(2, 0, 0);
        chk("bp2_valid", o_valid_a, 1);
        chk("bp2_acc", o_acc_a, 11);
        chk("bp2_scale", o_scale_a, 30);

        // Three back-to-back blocks with no bubble
        for (int i = 0; i < 12; i++) begin
            push(st_prd[i], (i % 4 == 0) ? st_s0[i/4] : 8'd0, (i % 4 == 0) ? st_s1[i/4] : 8'd0);
            if (i % 4 == 3) begin
                chk("st_valid", o_valid_a, 1);
                chk("st_acc", o_acc_a, st_sum[i/4]);
                chk("st_scale", o_scale_a, st_scl[i/4]);
            end else begin
                chk("st_valid_mid", o_valid_a, 0);
            end
        end
        @(posedge i_clk); #1;

        // Asynchronous reset mid-block discards the partial sum
        i_ready = 1'b0;
        repeat (4) push(9, 1, 1);
        chk("pr_acc", o_acc_a, 36);
        i_ready = 1'b1;
        push(100, 5, 5);
        push(100, 0, 0);
        chk("pr_first", o_first_a, 0);
        i_ready = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("ar_valid", o_valid_a, 0);
        chk("ar_acc", o_acc_a, 0);
        chk("ar_scale", o_scale_a, 0);
        chk("ar_first", o_first_a, 1);
        #2;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        push(1, 1, 1);
        push(1, 0, 0);
        push(1, 0, 0);
        push(1, 0, 0);
        chk("ar_blk_valid", o_valid_a, 1);
        chk("ar_blk_acc", o_acc_a, 4);
        chk("ar_blk_scale", o_scale_a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
